// File: rtl/dot_matrix_scanner_pkg.sv
// Shared constants and default parameters for the dot-matrix scanner.
package dot_matrix_pkg;

   localparam int unsigned ROWS_DEF         = 8;
   localparam int unsigned COLS_DEF         = 8;
   localparam int unsigned ROW_CYCLES_DEF   = 1000;
   localparam int unsigned BLINK_FRAMES_DEF = 32;

   // Wide enough for the largest legal ROWS / COLS; users slice to width.
   localparam logic [15:0] ROW_OFF = 16'hFFFF;
   localparam logic [31:0] COL_OFF = 32'h0000_0000;

endpackage

// File: rtl/dot_matrix_scanner_if.sv
// Write / swap bus between a framebuffer producer and the scanner.
interface dot_matrix_scanner_if #(
   parameter int unsigned ROWS = 8,
   parameter int unsigned COLS = 8
);
   logic                    wr_en;
   logic [$clog2(ROWS)-1:0] wr_row;
   logic [COLS-1:0]         wr_r;
   logic [COLS-1:0]         wr_g;
   logic                    swap_req;
   logic                    swap_pending;

   modport master (output wr_en, wr_row, wr_r, wr_g, swap_req, input swap_pending);
   modport slave  (input wr_en, wr_row, wr_r, wr_g, swap_req, output swap_pending);
endinterface

// File: rtl/dot_matrix_scanner_frame_buffer.sv
// Double framebuffer: back-buffer write port, front read port, frame-end swap.
module matrix_frame_buffer
   import dot_matrix_pkg::*;
#(
   parameter int unsigned ROWS = ROWS_DEF,
   parameter int unsigned COLS = COLS_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [$clog2(ROWS)-1:0] wr_row,
   input  logic [COLS-1:0]         wr_r,
   input  logic [COLS-1:0]         wr_g,
   input  logic                    swap_req,
   input  logic                    frame_end,
   input  logic [$clog2(ROWS)-1:0] rd_idx,
   output logic [COLS-1:0]         rd_r_c,
   output logic [COLS-1:0]         rd_g_c,
   output logic                    swap_pending
);
   localparam int unsigned WW = 2 * COLS;

   logic [WW-1:0] mem_q [2][ROWS];
   logic [WW-1:0] mem_d [2][ROWS];
   logic          front_sel_q, front_sel_d;
   logic          swap_pending_q, swap_pending_d;
   logic          swap_c;
   logic          wr_ok_c;
   logic [WW-1:0] rd_word_c;

   // Writes always target the pre-swap back buffer, so a coincident write shows in the new frame.
   always_comb begin
      mem_d          = mem_q;
      wr_ok_c        = (32'(wr_row) < ROWS);
      swap_c         = frame_end && (swap_pending_q || swap_req);
      front_sel_d    = front_sel_q ^ swap_c;
      swap_pending_d = swap_c ? 1'b0 : (swap_pending_q || swap_req);
      if (wr_en && wr_ok_c) begin
         mem_d[~front_sel_q][wr_row] = {wr_g, wr_r};
      end
      rd_word_c = mem_q[front_sel_q][rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q          <= '{default: '0};
         front_sel_q    <= 1'b0;
         swap_pending_q <= 1'b0;
      end else begin
         mem_q          <= mem_d;
         front_sel_q    <= front_sel_d;
         swap_pending_q <= swap_pending_d;
      end
   end

   assign rd_r_c       = rd_word_c[COLS-1:0];
   assign rd_g_c       = rd_word_c[WW-1:COLS];
   assign swap_pending = swap_pending_q;

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-multiplexed two-colour LED matrix driver with double buffering, blanking and blink.
module dot_matrix_scanner
   import dot_matrix_pkg::*;
#(
   parameter int unsigned ROWS         = ROWS_DEF,
   parameter int unsigned COLS         = COLS_DEF,
   parameter int unsigned ROW_CYCLES   = ROW_CYCLES_DEF,
   parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   blink_en,
   dot_matrix_scanner_if.slave    bus,
   output logic [ROWS-1:0]        row,
   output logic [COLS-1:0]        col_r,
   output logic [COLS-1:0]        col_g,
   output logic                   frame_start
);
   localparam int unsigned IW = $clog2(ROWS);
   localparam int unsigned TW = $clog2(ROW_CYCLES);
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [TW-1:0]   timer_q, timer_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic            blink_q, blink_d;
   logic [ROWS-1:0] row_q, row_d;
   logic [COLS-1:0] col_r_q, col_r_d;
   logic [COLS-1:0] col_g_q, col_g_d;
   logic            frame_start_q, frame_start_d;

   logic            row_end_c;
   logic            frame_end_c;
   logic [COLS-1:0] rd_r_c, rd_g_c;
   logic            swap_pending_w;

   matrix_frame_buffer #(.ROWS(ROWS), .COLS(COLS)) u_fb (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (bus.wr_en),
      .wr_row       (bus.wr_row),
      .wr_r         (bus.wr_r),
      .wr_g         (bus.wr_g),
      .swap_req     (bus.swap_req),
      .frame_end    (frame_end_c),
      .rd_idx       (idx_q),
      .rd_r_c       (rd_r_c),
      .rd_g_c       (rd_g_c),
      .swap_pending (swap_pending_w)
   );

   always_comb begin
      timer_d       = timer_q;
      idx_d         = idx_q;
      fcnt_d        = fcnt_q;
      blink_d       = blink_q;
      row_d         = ROW_OFF[ROWS-1:0];
      col_r_d       = COL_OFF[COLS-1:0];
      col_g_d       = COL_OFF[COLS-1:0];
      frame_start_d = 1'b0;

      row_end_c   = (timer_q == TW'(ROW_CYCLES - 1));
      frame_end_c = en && row_end_c && (idx_q == IW'(ROWS - 1));

      if (!en) begin
         timer_d = '0;
         idx_d   = '0;
         fcnt_d  = '0;
         blink_d = 1'b0;
      end else begin
         if (row_end_c) begin
            timer_d = '0;
            idx_d   = (idx_q == IW'(ROWS - 1)) ? '0 : idx_q + IW'(1);
         end else begin
            timer_d = timer_q + TW'(1);
         end

         if (!blink_en) begin
            fcnt_d  = '0;
            blink_d = 1'b0;
         end else if (frame_end_c) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
               fcnt_d  = '0;
               blink_d = ~blink_q;
            end else begin
               fcnt_d = fcnt_q + FW'(1);
            end
         end

         // Columns dark on the first cycle of each row and during the blink-off phase.
         row_d         = ~(ROWS'(1) << idx_q);
         frame_start_d = (timer_q == '0) && (idx_q == '0);
         if ((timer_q != '0) && !(blink_en && blink_q)) begin
            col_r_d = rd_r_c;
            col_g_d = rd_g_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q       <= '0;
         idx_q         <= '0;
         fcnt_q        <= '0;
         blink_q       <= 1'b0;
         row_q         <= ROW_OFF[ROWS-1:0];
         col_r_q       <= COL_OFF[COLS-1:0];
         col_g_q       <= COL_OFF[COLS-1:0];
         frame_start_q <= 1'b0;
      end else begin
         timer_q       <= timer_d;
         idx_q         <= idx_d;
         fcnt_q        <= fcnt_d;
         blink_q       <= blink_d;
         row_q         <= row_d;
         col_r_q       <= col_r_d;
         col_g_q       <= col_g_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign row              = row_q;
   assign col_r            = col_r_q;
   assign col_g            = col_g_q;
   assign frame_start      = frame_start_q;
   assign bus.swap_pending = swap_pending_w;

endmodule
